arq_tx_ctrl: RTL and testbench

ARQ_TX_CTRL -- requirements
Module: arq_tx_ctrl

---
 rtl/arq_tx_ctrl.sv | 138 +++++++++++++
 tb/tb_arq_tx_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arq_tx_ctrl.sv
// Stop-and-wait ARQ transmit controller: pops one word per frame, sends it,
// and resends on NACK or response timeout until acknowledged or retries run out.
module arq_tx_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_rx_ack,
  input  logic                  i_rx_nack,
  output logic                  o_busy,
  output logic                  o_frame_ok,
  output logic                  o_frame_drop,
  output logic [1:0]            o_retry_cnt,
  output logic [7:0]            o_ok_cnt
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    WAIT_RSP,
    DROP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [TIMER_W-1:0]    r_timer;
  logic [1:0]            r_retry_cnt;
  logic [7:0]            r_ok_cnt;
  logic                  r_frame_ok;
  logic                  w_ack_ok;
  logic                  w_fail;
  logic                  w_retry_left;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ack_ok     = 1'b0;
    w_fail       = 1'b0;
    w_retry_left = (r_retry_cnt < 2'(MAX_RETRY));
    o_fifo_rd_en = 1'b0;
    o_tx_valid   = 1'b0;
    o_busy       = 1'b1;
    o_frame_drop = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_enable && !i_fifo_empty) begin
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        o_fifo_rd_en = 1'b1;
        w_state_next = LOAD;
      end
      LOAD: begin
        w_state_next = SEND;
      end
      SEND: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready) begin
          w_state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // NACK takes priority over a coincident ACK
        if (i_rx_nack || (r_timer == TIMER_W'(TIMEOUT - 1))) begin
          w_fail       = 1'b1;
          w_state_next = w_retry_left ? SEND : DROP;
        end else if (i_rx_ack) begin
          w_ack_ok     = 1'b1;
          w_state_next = IDLE;
        end
      end
      DROP: begin
        o_frame_drop = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_ok_cnt    <= '0;
      r_frame_ok  <= 1'b0;
    end else begin
      r_frame_ok <= w_ack_ok;
      if (r_state == LOAD) begin
        r_hold      <= i_fifo_rd_data;
        r_retry_cnt <= '0;
      end
      // Timer is held at zero for the whole SEND so back-pressure never eats response time
      if (r_state == SEND) begin
        r_timer <= '0;
      end else if (r_state == WAIT_RSP) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_fail && w_retry_left) begin
        r_retry_cnt <= r_retry_cnt + 2'd1;
      end
      if (w_ack_ok) begin
        r_ok_cnt <= r_ok_cnt + 8'd1;
      end
    end
  end

  assign o_tx_data   = r_hold;
  assign o_retry_cnt = r_retry_cnt;
  assign o_ok_cnt    = r_ok_cnt;
  assign o_frame_ok  = r_frame_ok;

endmodule

// File: tb/tb_arq_tx_ctrl.sv
// Directed bench for arq_tx_ctrl: FIFO model, scoreboard of expected symbols and frame events.
module tb_arq_tx_ctrl;

  localparam int DW   = 4;
  localparam int MAXR = 3;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          tx_ready = 1'b0;
  logic          rx_ack = 1'b0;
  logic          rx_nack = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          frame_ok;
  logic          frame_drop;
  logic [1:0]    retry_cnt;
  logic [7:0]    ok_cnt;

  arq_tx_ctrl #(.DATA_WIDTH(DW), .MAX_RETRY(MAXR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_fifo_empty(fifo_empty),
    .o_fifo_rd_en(fifo_rd_en), .i_fifo_rd_data(fifo_rd_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
    .i_rx_ack(rx_ack), .i_rx_nack(rx_nack), .o_busy(busy),
    .o_frame_ok(frame_ok), .o_frame_drop(frame_drop),
    .o_retry_cnt(retry_cnt), .o_ok_cnt(ok_cnt)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            rd_cnt = 0;
  int            push_cnt = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] tx_q[$];
  int            ev_q[$];
  logic [7:0]    exp_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Source FIFO model: word appears the cycle after the pop strobe
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en) begin
      rd_cnt++;
      chk("fifo_pop_avail", 32'(fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Scoreboard: every handshake and every frame event is matched against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        $display("[TB] cycle %0d send data=%h retry=%0d", cyc, tx_data, retry_cnt);
        chk("tx_expected", 32'(tx_q.size() > 0), 1);
        if (tx_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
      end
      if (frame_ok || frame_drop) begin
        $display("[TB] cycle %0d frame ok=%0b drop=%0b ok_cnt=%0d", cyc, frame_ok, frame_drop, ok_cnt);
        chk("event_expected", 32'(ev_q.size() > 0), 1);
        if (ev_q.size() > 0) chk("frame_event", {30'd0, frame_drop, frame_ok}, 32'(ev_q.pop_front()));
      end
    end
  end

  task automatic push_frame(input logic [DW-1:0] word, input int nsends, input int ev);
    fifo_q.push_back(word);
    push_cnt++;
    for (int k = 0; k < nsends; k++) tx_q.push_back(word);
    if (ev != 0) ev_q.push_back(ev);
  endtask

  task automatic await_hs(output int at_cyc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hs_seen", 32'(ok), 1);
    at_cyc = cyc;
  endtask

  // kind: 0 none, 1 ack, 2 nack, 3 ack+nack; driven during the first WAIT_RSP cycle
  task automatic respond(input int kind);
    @(posedge clk);
    #1;
    rx_ack  = (kind == 1) || (kind == 3);
    rx_nack = (kind == 2) || (kind == 3);
    @(posedge clk);
    #1;
    rx_ack  = 1'b0;
    rx_nack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    int hs[4];
    bit seen;
    exp_ok = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_frame_ok", 32'(frame_ok), 0);
    chk("rst_frame_drop", 32'(frame_drop), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_ok_cnt", 32'(ok_cnt), 0);
    rst = 1'b0;
    enable = 1'b1;
    tx_ready = 1'b1;

    // Single word, immediate ACK, with latency check
    push_frame(4'hA, 1, 1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("fetch_seen", 32'(seen), 1);
    @(negedge clk);
    chk("rd_en_one_cycle", 32'(fifo_rd_en), 0);
    chk("load_no_valid", 32'(tx_valid), 0);
    @(negedge clk);
    chk("latency_tx_valid", 32'(tx_valid), 1);
    respond(1);
    exp_ok++;
    chk("t1_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
    chk("t1_retry", 32'(retry_cnt), 0);
    chk("t1_idle", 32'(busy), 0);

    // NACK, NACK, ACK; enable dropped mid-frame must not abort it
    push_frame(4'h5, 3, 1);
    await_hs(c0);
    enable = 1'b0;
    respond(2);
    await_hs(c0);
    respond(2);
    await_hs(c0);
    respond(1);
    exp_ok++;
    chk("t2_retry", 32'(retry_cnt), 2);
    chk("t2_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
    enable = 1'b1;

    // No response at all: four sends one timeout apart, then a drop
    push_frame(4'h3, 4, 2);
    for (int k = 0; k < 4; k++) begin
      await_hs(hs[k]);
      if (k > 0) chk("timeout_spacing", 32'(hs[k] - hs[k-1]), TO + 1);
    end
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (frame_drop) begin
        seen = 1'b1;
        break;
      end
    end
    chk("drop_seen", 32'(seen), 1);
    chk("drop_timing", 32'(cyc - hs[3]), TO + 1);
    chk("drop_retry", 32'(retry_cnt), MAXR);
    chk("drop_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
    @(negedge clk);
    chk("drop_one_cycle", 32'(frame_drop), 0);
    chk("drop_idle", 32'(busy), 0);

    // ACK and NACK together count as NACK
    push_frame(4'h6, 2, 1);
    await_hs(c0);
    respond(3);
    chk("both_retry", 32'(retry_cnt), 1);
    chk("both_resend", 32'(tx_valid), 1);
    await_hs(c0);
    respond(1);
    exp_ok++;
    chk("both_ok_cnt", 32'(ok_cnt), 32'(exp_ok));

    // Responses outside WAIT_RSP are ignored
    rx_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_ack = 1'b0;
    chk("stray_ack_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
    chk("stray_ack_idle", 32'(busy), 0);

    // Back-pressure in SEND, then reset during WAIT_RSP
    tx_ready = 1'b0;
    push_frame(4'h9, 2, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_valid_seen", 32'(seen), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(tx_valid), 1);
      chk("stall_data", 32'(tx_data), 32'h9);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    await_hs(c0);
    await_hs(c1);
    chk("stall_timeout_spacing", 32'(c1 - c0), TO + 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_rd_en", 32'(fifo_rd_en), 0);
    chk("midrst_frame_ok", 32'(frame_ok), 0);
    chk("midrst_frame_drop", 32'(frame_drop), 0);
    chk("midrst_retry", 32'(retry_cnt), 0);
    chk("midrst_ok_cnt", 32'(ok_cnt), 0);
    exp_ok = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 256 acknowledged frames: ok_cnt wraps to zero
    for (int i = 0; i < 256; i++) begin
      push_frame(DW'(i), 1, 1);
      await_hs(c0);
      respond(1);
      exp_ok++;
      chk("wrap_ok_cnt", 32'(ok_cnt), 32'(exp_ok));
    end
    chk("wrap_final_zero", 32'(ok_cnt), 0);

    // IDLE holds with empty FIFO, and with enable low
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("empty_no_rd", 32'(fifo_rd_en), 0);
      chk("empty_idle", 32'(busy), 0);
    end
    enable = 1'b0;
    push_frame(4'hC, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("disabled_no_rd", 32'(fifo_rd_en), 0);
      chk("disabled_idle", 32'(busy), 0);
    end
    enable = 1'b1;
    await_hs(c0);
    respond(1);
    exp_ok++;
    chk("reenable_ok_cnt", 32'(ok_cnt), 32'(exp_ok));

    // Everything expected was produced, and nothing more
    repeat (3) @(negedge clk);
    chk("tx_q_drained", 32'(tx_q.size()), 0);
    chk("ev_q_drained", 32'(ev_q.size()), 0);
    chk("fifo_drained", 32'(fifo_q.size()), 0);
    chk("pop_count", 32'(rd_cnt), 32'(push_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
